// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, derived totals and active-area offsets.
package vga_pkg;

    // Width of the H and V counters; wide enough for any practical mode.
    localparam int unsigned CNT_W = 16;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FRONT  = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BACK   = 48;

    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FRONT  = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BACK   = 33;

    localparam int unsigned VGA_H_TOTAL =
        VGA_H_SYNC + VGA_H_BACK + VGA_H_ACTIVE + VGA_H_FRONT;
    localparam int unsigned VGA_V_TOTAL =
        VGA_V_SYNC + VGA_V_BACK + VGA_V_ACTIVE + VGA_V_FRONT;

    // The active area starts right after sync and back porch.
    function automatic int unsigned act_start(input int unsigned sync_w,
                                              input int unsigned back_w);
        return sync_w + back_w;
    endfunction

    localparam int unsigned VGA_H_ACT_START = act_start(VGA_H_SYNC, VGA_H_BACK);
    localparam int unsigned VGA_V_ACT_START = act_start(VGA_V_SYNC, VGA_V_BACK);

    // Per-pixel control bits carried down the output pipeline.
    typedef struct packed {
        logic hs;   // raw horizontal sync (asserted, before polarity)
        logic vs;   // raw vertical sync
        logic act;  // pixel is in the active area
        logic fs;   // H=0, V=0
    } ctrl_t;

endpackage

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: free-running H/V counters with raw sync and active decode.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FRONT  = VGA_H_FRONT,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BACK   = VGA_H_BACK,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FRONT  = VGA_V_FRONT,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BACK   = VGA_V_BACK
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [CNT_W-1:0] h_o,
    output logic [CNT_W-1:0] v_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             active_o
);

    localparam logic [CNT_W-1:0] HLast    = CNT_W'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
    localparam logic [CNT_W-1:0] VLast    = CNT_W'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
    localparam logic [CNT_W-1:0] HSyncEnd = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VSyncEnd = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] HActBeg  = CNT_W'(act_start(H_SYNC, H_BACK));
    localparam logic [CNT_W-1:0] VActBeg  = CNT_W'(act_start(V_SYNC, V_BACK));
    localparam logic [CNT_W-1:0] HActEnd  = CNT_W'(act_start(H_SYNC, H_BACK) + H_ACTIVE);
    localparam logic [CNT_W-1:0] VActEnd  = CNT_W'(act_start(V_SYNC, V_BACK) + V_ACTIVE);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    // Next-state: H wraps at line end, V steps only on H wrap.
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == HLast) begin
            h_d = '0;
            v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Raw decode of the current counter position.
    always_comb begin
        h_o      = h_q;
        v_o      = v_q;
        hsync_o  = (h_q < HSyncEnd);
        vsync_o  = (v_q < VSyncEnd);
        active_o = (h_q >= HActBeg) && (h_q < HActEnd) && (v_q >= VActBeg) && (v_q < VActEnd);
    end

endmodule

// File: rtl/vga_pipelined_controller.sv
// vga_pipelined_controller: VGA timing with pipelined frame-buffer reads.
// Define VGA_TEST_PATTERN_EN to add the PAT_SEL colour-bar source.
module vga_pipelined_controller
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
    parameter int unsigned H_FRONT     = VGA_H_FRONT,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BACK      = VGA_H_BACK,
    parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
    parameter int unsigned V_FRONT     = VGA_V_FRONT,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BACK      = VGA_V_BACK,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned COLOR_W     = 4,
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned MEM_LAT     = 1,
    parameter bit          SYNC_POL    = 1'b1
) (
    input  logic                 VGA_CLK,
    input  logic                 VGA_RST,
    input  logic [3*COLOR_W-1:0] VGA_DATA,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                 PAT_SEL,
`endif
    output logic [ADDR_W-1:0]    VGA_ADDR,
    output logic                 VGA_ADDR_VALID,
    output logic [COLOR_W-1:0]   VGA_R,
    output logic [COLOR_W-1:0]   VGA_G,
    output logic [COLOR_W-1:0]   VGA_B,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic                 VGA_BLANK_N,
    output logic                 FRAME_START
);

    // Stage 0 plus MEM_LAT memory stages plus the output register.
    localparam int unsigned Depth = MEM_LAT + 2;
    localparam logic [CNT_W-1:0] HStart = CNT_W'(act_start(H_SYNC, H_BACK));
    localparam logic [CNT_W-1:0] VStart = CNT_W'(act_start(V_SYNC, V_BACK));
    localparam logic [31:0] LineWords = 32'(H_ACTIVE >> SCALE_SHIFT);

    logic [CNT_W-1:0]     h_cnt, v_cnt;
    logic                 h_sync, v_sync, active;
    logic [CNT_W-1:0]     hx, vy;
    logic [31:0]          addr_full;
    logic [ADDR_W-1:0]    addr_d, addr_q;
    logic                 addr_valid_q;
    ctrl_t                ctrl_d;
    ctrl_t                ctrl_q [Depth];
    logic [3*COLOR_W-1:0] src;
    logic [3*COLOR_W-1:0] rgb_d, rgb_q;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK)
    ) u_timing (
        .clk_i    (VGA_CLK),
        .rst_i    (VGA_RST),
        .h_o      (h_cnt),
        .v_o      (v_cnt),
        .hsync_o  (h_sync),
        .vsync_o  (v_sync),
        .active_o (active)
    );

    // Stage-0 next-state: scaled frame-buffer address and control bits.
    always_comb begin
        hx        = h_cnt - HStart;
        vy        = v_cnt - VStart;
        addr_full = 32'(hx >> SCALE_SHIFT) + 32'(vy >> SCALE_SHIFT) * LineWords;
        addr_d    = active ? addr_full[ADDR_W-1:0] : '0;
        ctrl_d.hs  = h_sync;
        ctrl_d.vs  = v_sync;
        ctrl_d.act = active;
        ctrl_d.fs  = (h_cnt == '0) && (v_cnt == '0);
    end

    // Address register and control shift pipeline, aligned to memory latency.
    always_ff @(posedge VGA_CLK) begin
        if (VGA_RST) begin
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            for (int i = 0; i < Depth; i++) ctrl_q[i] <= '0;
        end else begin
            addr_q       <= addr_d;
            addr_valid_q <= active;
            ctrl_q[0]    <= ctrl_d;
            for (int i = 1; i < Depth; i++) ctrl_q[i] <= ctrl_q[i-1];
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_d;
    // Bar index only has to reach the stage where memory data arrives.
    logic [2:0] bar_q [Depth-1];

    // Bar index for the current stage-0 pixel.
    always_comb bar_d = 3'((32'(hx) * 32'd8) / H_ACTIVE);

    // Bar index pipeline, in step with ctrl_q.
    always_ff @(posedge VGA_CLK) begin
        if (VGA_RST) begin
            for (int i = 0; i < Depth - 1; i++) bar_q[i] <= '0;
        end else begin
            bar_q[0] <= bar_d;
            for (int i = 1; i < Depth - 1; i++) bar_q[i] <= bar_q[i-1];
        end
    end
`endif

    // Pixel source: memory data, optionally replaced by colour bars.
    always_comb begin
        src = VGA_DATA;
`ifdef VGA_TEST_PATTERN_EN
        if (PAT_SEL) begin
            src = {{COLOR_W{bar_q[MEM_LAT][2]}}, {COLOR_W{bar_q[MEM_LAT][1]}},
                   {COLOR_W{bar_q[MEM_LAT][0]}}};
        end
`endif
        rgb_d = ctrl_q[MEM_LAT].act ? src : '0;
    end

    // Registered colour output, blanked outside the active area.
    always_ff @(posedge VGA_CLK) begin
        if (VGA_RST) rgb_q <= '0;
        else         rgb_q <= rgb_d;
    end

    assign VGA_ADDR       = addr_q;
    assign VGA_ADDR_VALID = addr_valid_q;
    assign VGA_R          = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign VGA_G          = rgb_q[2*COLOR_W-1:COLOR_W];
    assign VGA_B          = rgb_q[COLOR_W-1:0];
    assign VGA_HS         = ctrl_q[Depth-1].hs ? SYNC_POL : ~SYNC_POL;
    assign VGA_VS         = ctrl_q[Depth-1].vs ? SYNC_POL : ~SYNC_POL;
    assign VGA_BLANK_N    = ctrl_q[Depth-1].act;
    assign FRAME_START    = ctrl_q[Depth-1].fs;

endmodule

// File: tb/tb_vga_pipelined_controller.sv
// tb_vga_pipelined_controller: default-mode instance (a) and a small-mode instance (b)
// with MEM_LAT=2, SYNC_POL=0, checked against a position-based reference model.
module tb_vga_pipelined_controller;

    localparam int HA = 32, HF = 4, HSY = 6, HB = 5;
    localparam int VA = 16, VF = 2, VSY = 2, VB = 3;
    localparam int SS = 1, AW = 8, ML = 2;
    localparam bit POL = 1'b0;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FRAME = HT * VT;
    localparam int LB = ML + 2;   // counter position to pixel output, instance b
    localparam int LA = 3;        // same for instance a (MEM_LAT=1)

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic [11:0] data_a, data_b, mem1, mem2, key;
    logic [18:0] addr_a;
    logic        valid_a, hs_a, vs_a, blank_a, fs_a;
    logic [3:0]  r_a, g_a, b_a;
    logic [AW-1:0] addr_b;
    logic        valid_b, hs_b, vs_b, blank_b, fs_b;
    logic [3:0]  r_b, g_b, b_b;
`ifdef VGA_TEST_PATTERN_EN
    logic        pat_a = 1'b0, pat_b = 1'b0;
`endif

    int checks = 0, errors = 0;
    int ka, kb;
    int vs_a_cnt = 0;

    vga_pipelined_controller u_dut_a (
        .VGA_CLK(clk), .VGA_RST(rst_a), .VGA_DATA(data_a),
`ifdef VGA_TEST_PATTERN_EN
        .PAT_SEL(pat_a),
`endif
        .VGA_ADDR(addr_a), .VGA_ADDR_VALID(valid_a), .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a),
        .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(blank_a), .FRAME_START(fs_a)
    );

    vga_pipelined_controller #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .SCALE_SHIFT(SS), .COLOR_W(4), .ADDR_W(AW), .MEM_LAT(ML), .SYNC_POL(POL)
    ) u_dut_b (
        .VGA_CLK(clk), .VGA_RST(rst_b), .VGA_DATA(data_b),
`ifdef VGA_TEST_PATTERN_EN
        .PAT_SEL(pat_b),
`endif
        .VGA_ADDR(addr_b), .VGA_ADDR_VALID(valid_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(blank_b), .FRAME_START(fs_b)
    );

    function automatic logic [11:0] mem_word(input int a);
        return 12'(a) ^ key;
    endfunction

    // Cycle counters since reset release; frame-buffer models with MEM_LAT delay.
    always @(posedge clk) begin
        ka     <= rst_a ? 0 : ka + 1;
        kb     <= rst_b ? 0 : kb + 1;
        mem1   <= mem_word(int'(addr_b));
        mem2   <= mem1;
        data_a <= 12'(addr_a);
    end
    assign data_b = mem2;

    // Asserted VS clocks of instance a over its first frame.
    always @(negedge clk) if (!rst_a && vs_a) vs_a_cnt <= vs_a_cnt + 1;

    // Reference model for instance b: position p counts clocks since the frame origin.
    function automatic int pos_h(input int p); return (p % FRAME) % HT; endfunction
    function automatic int pos_v(input int p); return (p % FRAME) / HT; endfunction
    function automatic bit is_act(input int p);
        int h, v;
        h = pos_h(p); v = pos_v(p);
        return (h >= HSY + HB) && (h < HSY + HB + HA) && (v >= VSY + VB) && (v < VSY + VB + VA);
    endfunction
    function automatic int addr_of(input int p);
        if (!is_act(p)) return 0;
        return (((pos_h(p) - HSY - HB) >> SS) + ((pos_v(p) - VSY - VB) >> SS) * (HA >> SS))
               % (1 << AW);
    endfunction
    function automatic logic [11:0] pix_of(input int p, input bit pat);
        int bar;
        if (!is_act(p)) return 12'h000;
        if (pat) begin
            bar = (pos_h(p) - HSY - HB) * 8 / HA;
            return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
        end
        return mem_word(addr_of(p));
    endfunction

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({addr_b, valid_b, r_b, g_b, b_b, blank_b, fs_b} !== '0) begin
                errors++; $display("FAIL reset_b_outputs got %h want 0",
                                   {addr_b, valid_b, r_b, g_b, b_b, blank_b, fs_b});
            end
            checks++;
            if (hs_b !== !POL || vs_b !== !POL) begin
                errors++; $display("FAIL reset_b_sync got hs=%b vs=%b want %b", hs_b, vs_b, !POL);
            end
            checks++;
            if ({addr_a, valid_a, r_a, g_a, b_a, blank_a, fs_a, hs_a, vs_a} !== '0) begin
                errors++; $display("FAIL reset_a_outputs got %h want 0",
                                   {addr_a, valid_a, r_a, g_a, b_a, blank_a, fs_a, hs_a, vs_a});
            end
        end
        rst_a = 1'b0; rst_b = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++;
            if (fs_a !== (ka == LA)) begin
                errors++; $display("FAIL first_frame_start_a k=%0d got %b want %b",
                                   ka, fs_a, ka == LA);
            end
        end
    endtask

    task automatic test_pipeline(input int ncyc, input bit pat);
        int k, p, ea;
        bit ev, ehs, evs, ebl, efs;
        logic [11:0] erg;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            k  = kb;
            ea = (k == 0) ? 0 : addr_of(k - 1);
            ev = (k > 0) && is_act(k - 1);
            if (k >= LB) begin
                p   = k - LB;
                ehs = (pos_h(p) < HSY) ? POL : !POL;
                evs = (pos_v(p) < VSY) ? POL : !POL;
                ebl = is_act(p);
                efs = (p % FRAME) == 0;
                erg = pix_of(p, pat);
            end else begin
                ehs = !POL; evs = !POL; ebl = 1'b0; efs = 1'b0; erg = 12'h000;
            end
            checks++;
            if (addr_b !== AW'(ea) || valid_b !== ev) begin
                errors++; $display("FAIL addr k=%0d got %0d/%b want %0d/%b",
                                   k, addr_b, valid_b, ea, ev);
            end
            checks++;
            if (hs_b !== ehs || vs_b !== evs) begin
                errors++; $display("FAIL sync k=%0d got hs=%b vs=%b want hs=%b vs=%b",
                                   k, hs_b, vs_b, ehs, evs);
            end
            checks++;
            if (blank_b !== ebl || fs_b !== efs) begin
                errors++; $display("FAIL blank_fs k=%0d got %b/%b want %b/%b",
                                   k, blank_b, fs_b, ebl, efs);
            end
            checks++;
            if ({r_b, g_b, b_b} !== erg) begin
                errors++; $display("FAIL rgb k=%0d got %h want %h", k, {r_b, g_b, b_b}, erg);
            end
        end
    endtask

    task automatic test_latency();
        int p0, p1;
        p0 = (VSY + VB) * HT + HSY + HB;  // first active pixel
        p1 = p0 + (1 << SS);              // first pixel reading address 1
        @(negedge clk); rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        for (int n = 0; n < p1 + 8; n++) begin
            @(negedge clk);
            if (kb == p0 + LB - 1) begin
                checks++;
                if (blank_b !== 1'b0) begin
                    errors++; $display("FAIL blank_before_first got %b want 0", blank_b);
                end
            end
            if (kb == p0 + LB) begin
                checks++;
                if (blank_b !== 1'b1 || {r_b, g_b, b_b} !== mem_word(0)) begin
                    errors++; $display("FAIL first_pixel got %b/%h want 1/%h",
                                       blank_b, {r_b, g_b, b_b}, mem_word(0));
                end
            end
            if (kb == p1 + 1) begin
                checks++;
                if (addr_b !== AW'(1) || valid_b !== 1'b1) begin
                    errors++; $display("FAIL addr1_issue got %0d/%b want 1/1", addr_b, valid_b);
                end
            end
            if (kb == p1 + 1 + ML + 1) begin
                checks++;
                if ({r_b, g_b, b_b} !== mem_word(1)) begin
                    errors++; $display("FAIL addr1_latency got %h want %h",
                                       {r_b, g_b, b_b}, mem_word(1));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int nr;
        repeat ($urandom_range(50, FRAME - 50)) @(negedge clk);
        nr = int'($urandom_range(1, 4));
        rst_b = 1'b1;
        repeat (nr) begin
            @(negedge clk);
            checks++;
            if ({addr_b, valid_b, r_b, g_b, b_b, blank_b, fs_b} !== '0 ||
                hs_b !== !POL || vs_b !== !POL) begin
                errors++; $display("FAIL mid_reset_values got %h hs=%b vs=%b",
                                   {addr_b, valid_b, r_b, g_b, b_b, blank_b, fs_b}, hs_b, vs_b);
            end
        end
        rst_b = 1'b0;
        for (int n = 0; n <= LB + 2; n++) begin
            if (n > 0) @(negedge clk);
            checks++;
            if (fs_b !== (kb == LB)) begin
                errors++; $display("FAIL frame_start_after_reset k=%0d got %b want %b",
                                   kb, fs_b, kb == LB);
            end
        end
    endtask

    task automatic test_sync_pol();
        logic ph, pv;
        int hfall, vfall, nh, nw, nv;
        ph = hs_b; pv = vs_b; hfall = -1; vfall = -1; nh = 0; nw = 0; nv = 0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk);
            if (!hs_b && ph) begin
                if (hfall >= 0 && nh < 4) begin
                    checks++; nh++;
                    if (kb - hfall != HT) begin
                        errors++; $display("FAIL hs_period got %0d want %0d", kb - hfall, HT);
                    end
                end
                hfall = kb;
            end
            if (hs_b && !ph && hfall >= 0 && nw < 4) begin
                checks++; nw++;
                if (kb - hfall != HSY) begin
                    errors++; $display("FAIL hs_low_width got %0d want %0d", kb - hfall, HSY);
                end
            end
            if (!vs_b && pv) vfall = kb;
            if (vs_b && !pv && vfall >= 0) begin
                checks++; nv++;
                if (kb - vfall != VSY * HT) begin
                    errors++; $display("FAIL vs_low_width got %0d want %0d",
                                       kb - vfall, VSY * HT);
                end
            end
            ph = hs_b; pv = vs_b;
        end
        checks++;
        if (nv == 0 || nw == 0) begin
            errors++; $display("FAIL sync_seen got vs=%0d hs=%0d want nonzero", nv, nw);
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        @(negedge clk); rst_b = 1'b1; pat_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        test_pipeline(FRAME + 20, 1'b1);
        @(negedge clk); rst_b = 1'b1; pat_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
    endtask
`endif

    task automatic test_default_timing();
        int tgt, hs_rise, nper, nwid, fs_seen;
        logic prev_hs;
        tgt = 39 * 800 + 145;
        prev_hs = hs_a; hs_rise = -1; nper = 0; nwid = 0; fs_seen = 0;
        for (int n = 0; n < 40000 && ka <= tgt; n++) begin
            @(negedge clk);
            if (hs_a && !prev_hs) begin
                if (hs_rise >= 0 && nper < 3) begin
                    checks++; nper++;
                    if (ka - hs_rise != 800) begin
                        errors++; $display("FAIL a_hs_period got %0d want 800", ka - hs_rise);
                    end
                end
                hs_rise = ka;
            end
            if (!hs_a && prev_hs && hs_rise >= 0 && nwid < 3) begin
                checks++; nwid++;
                if (ka - hs_rise != 96) begin
                    errors++; $display("FAIL a_hs_width got %0d want 96", ka - hs_rise);
                end
            end
            prev_hs = hs_a;
            if (fs_a) fs_seen++;
            if (ka == 35 * 800 + 143 + 1) begin
                checks++;
                if (valid_a !== 1'b0) begin
                    errors++; $display("FAIL a_probe_h143 got valid=%b want 0", valid_a);
                end
            end
            if (ka == 35 * 800 + 144 + 1) begin
                checks++;
                if (addr_a !== 19'd0 || valid_a !== 1'b1) begin
                    errors++; $display("FAIL a_probe_h144 got %0d/%b want 0/1", addr_a, valid_a);
                end
            end
            if (ka == 35 * 800 + 148 + 1) begin
                checks++;
                if (addr_a !== 19'd1) begin
                    errors++; $display("FAIL a_probe_h148 got %0d want 1", addr_a);
                end
            end
            if (ka == tgt) begin
                checks++;
                if (addr_a !== 19'd160) begin
                    errors++; $display("FAIL a_probe_v39 got %0d want 160", addr_a);
                end
            end
        end
        checks++;
        if (ka <= tgt) begin
            errors++; $display("FAIL a_timeout got k=%0d want >%0d", ka, tgt);
        end
        checks++;
        if (fs_seen != 0) begin
            errors++; $display("FAIL a_extra_frame_start got %0d want 0", fs_seen);
        end
        checks++;
        if (vs_a_cnt != 1600) begin
            errors++; $display("FAIL a_vs_width got %0d want 1600", vs_a_cnt);
        end
    endtask

    initial begin
        key = 12'($urandom);
        test_reset();
        test_latency();
        test_pipeline(2 * FRAME + 30, 1'b0);
        test_mid_reset();
        test_pipeline(FRAME + 30, 1'b0);
        test_sync_pol();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        test_default_timing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
